// File: rtl/pixel_packetizer.sv
// Frames a free-running camera pixel stream into valid/ready packets with sop/eop.
// A small FIFO absorbs backpressure; when full, new pixels merge into the newest entry.
`timescale 1ns/1ps
module pixel_packetizer #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start_in,
    input  logic              pixel_valid_in,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic              overflow_out,
    output logic              short_frame_out,
    output logic              frame_done_out
);
    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);
    localparam logic [AW:0]   Depth = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {StIdle, StActive} state_e;

    state_e         state_q, state_d;
    logic [XW-1:0]  x_q, x_d, cur_x;
    logic [YW-1:0]  y_q, y_d, cur_y;
    logic [AW:0]    wptr_q, rptr_q, fill;
    logic [AW-1:0]  last_idx;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head;
    logic           overflow_q, overflow_d;
    logic           short_q, done_q;
    logic           push, pix_sop, pix_eop;
    logic           empty, full, pop, do_write, do_merge;

    // A frame_start in the same cycle as a pixel makes that pixel (0,0).
    always_comb begin
        cur_x   = frame_start_in ? '0 : x_q;
        cur_y   = frame_start_in ? '0 : y_q;
        push    = pixel_valid_in && (frame_start_in || (state_q == StActive));
        pix_sop = (cur_x == '0) && (cur_y == '0);
        pix_eop = (cur_x == XLast) && (cur_y == YLast);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (frame_start_in) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
        end
        if (push) begin
            if (pix_eop) begin
                state_d = StIdle;
                x_d     = '0;
                y_d     = '0;
            end else if (cur_x == XLast) begin
                x_d = '0;
                y_d = cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    always_comb begin
        fill     = wptr_q - rptr_q;
        empty    = (wptr_q == rptr_q);
        full     = (fill == Depth);
        pop      = !empty && ready_in;
        do_write = push && (!full || pop);
        do_merge = push && full && !pop;
        last_idx = AW'(wptr_q - 1'b1);
        head     = mem[rptr_q[AW-1:0]];
    end

    // Overflow clears only on a fresh frame seen from idle; a merge in that cycle wins.
    always_comb begin
        overflow_d = overflow_q;
        if (frame_start_in && (state_q == StIdle)) begin
            overflow_d = 1'b0;
        end
        if (do_merge) begin
            overflow_d = 1'b1;
        end
    end

    // Merging keeps framing: sop/eop accumulate so a packet boundary is never lost.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr_q[AW-1:0]] <= {pix_sop, pix_eop, pixel_in};
        end else if (do_merge) begin
            mem[last_idx] <= {mem[last_idx][EW-1] | pix_sop,
                              mem[last_idx][EW-2] | pix_eop, pixel_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            if (do_write) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            overflow_q <= overflow_d;
            short_q    <= frame_start_in && (state_q == StActive);
            done_q     <= pop && head[EW-2];
        end
    end

    always_comb begin
        valid_out         = !empty;
        data_out          = valid_out ? head[DATA_W-1:0] : '0;
        startofpacket_out = valid_out && head[EW-1];
        endofpacket_out   = valid_out && head[EW-2];
        overflow_out      = overflow_q;
        short_frame_out   = short_q;
        frame_done_out    = done_q;
    end

endmodule

// File: tb/tb_pixel_packetizer.sv
// Directed bench for pixel_packetizer with a 4x2 frame and a 4-entry FIFO.
`timescale 1ns/1ps
module tb_pixel_packetizer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fs, pv, rdy;
    logic [11:0] pix;
    logic        valid_out, startofpacket_out, endofpacket_out;
    logic        overflow_out, short_frame_out, frame_done_out;
    logic [11:0] data_out;
    logic [14:0] obs;
    logic [2:0]  flags;
    int          errors = 0;
    int          checks = 0;

    assign obs   = {valid_out, startofpacket_out, endofpacket_out, data_out};
    assign flags = {overflow_out, short_frame_out, frame_done_out};

    always #5 clk = ~clk;

    pixel_packetizer #(
        .WIDTH      (4),
        .HEIGHT     (2),
        .DATA_W     (12),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .frame_start_in    (fs),
        .pixel_valid_in    (pv),
        .pixel_in          (pix),
        .ready_in          (rdy),
        .valid_out         (valid_out),
        .data_out          (data_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .overflow_out      (overflow_out),
        .short_frame_out   (short_frame_out),
        .frame_done_out    (frame_done_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        fs = 1'b0; pv = 1'b0; rdy = 1'b0; pix = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({obs, flags} !== 18'h0) begin
            errors++; $display("FAIL reset_values: got %h want 0", {obs, flags});
        end
        for (int i = 1; i <= 3; i++) begin
            fs = (i == 1); pv = 1'b1; pix = 12'(12'h400 + i);
            step();
        end
        fs = 1'b0; pv = 1'b0;
        checks++;
        if (obs !== {3'b110, 12'h401}) begin
            errors++; $display("FAIL reset_queued: got %h want %h", obs, {3'b110, 12'h401});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({obs, flags} !== 18'h0) begin
            errors++; $display("FAIL reset_async: got %h want 0", {obs, flags});
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid_out !== 1'b0) begin
                errors++; $display("FAIL reset_after_release: got %b want 0", valid_out);
            end
        end
    endtask

    task automatic test_nominal();
        logic [14:0] exp;
        apply_reset();
        rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            fs = (i == 1); pv = 1'b1; pix = 12'(i);
            step();
            exp = {1'b1, i == 1, i == 8, 12'(i)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL nominal_beat%0d: got %h want %h", i, obs, exp);
            end
            checks++;
            if (frame_done_out !== 1'b0) begin
                errors++; $display("FAIL nominal_done_early%0d: got %b want 0", i, frame_done_out);
            end
        end
        fs = 1'b0; pv = 1'b0;
        step();
        checks++;
        if ({valid_out, frame_done_out} !== 2'b01) begin
            errors++;
            $display("FAIL nominal_done: got %b want 01", {valid_out, frame_done_out});
        end
        step();
        checks++;
        if (frame_done_out !== 1'b0) begin
            errors++; $display("FAIL nominal_done_once: got %b want 0", frame_done_out);
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] exp;
        apply_reset();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fs = (i == 0); pv = 1'b1; pix = 12'(12'h201 + i);
            step();
        end
        fs = 1'b0; pv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== {3'b110, 12'h201}) begin
                errors++; $display("FAIL bp_stall%0d: got %h want %h", i, obs, {3'b110, 12'h201});
            end
            step();
        end
        rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp = (k == 3) ? 15'h0 : {3'b100, 12'(12'h201 + k)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL bp_drain%0d: got %h want %h", k, obs, exp);
            end
        end
        checks++;
        if (overflow_out !== 1'b0) begin
            errors++; $display("FAIL bp_overflow: got %b want 0", overflow_out);
        end
    endtask

    task automatic test_overflow();
        logic [14:0] exp_a [4];
        logic [14:0] exp_b [4];
        exp_a = '{{3'b110, 12'h101}, {3'b100, 12'h102}, {3'b100, 12'h103}, {3'b100, 12'h106}};
        exp_b = '{{3'b110, 12'h101}, {3'b100, 12'h102}, {3'b100, 12'h103}, {3'b101, 12'h108}};
        apply_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            fs = (i == 1); pv = 1'b1; pix = 12'(12'h100 + i);
            step();
            if (i == 4 || i == 5) begin
                checks++;
                if (overflow_out !== (i == 5)) begin
                    errors++; $display("FAIL ovf_flag_px%0d: got %b want %b", i, overflow_out, i == 5);
                end
            end
        end
        fs = 1'b0; pv = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs !== exp_a[k]) begin
                errors++; $display("FAIL ovf_merge%0d: got %h want %h", k, obs, exp_a[k]);
            end
            step();
        end
        checks++;
        if ({valid_out, overflow_out} !== 2'b01) begin
            errors++; $display("FAIL ovf_after_drain: got %b want 01", {valid_out, overflow_out});
        end

        apply_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            fs = (i == 1); pv = 1'b1; pix = 12'(12'h100 + i);
            step();
        end
        fs = 1'b0; pv = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs !== exp_b[k]) begin
                errors++; $display("FAIL ovf_eop%0d: got %h want %h", k, obs, exp_b[k]);
            end
            step();
        end
        checks++;
        if ({valid_out, frame_done_out} !== 2'b01) begin
            errors++; $display("FAIL ovf_done: got %b want 01", {valid_out, frame_done_out});
        end
    endtask

    task automatic test_short_frame();
        logic [14:0] exp;
        apply_reset();
        rdy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            fs = (i == 1); pv = 1'b1; pix = 12'(12'h300 + i);
            step();
            exp = {1'b1, i == 1, 1'b0, 12'(12'h300 + i)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL short_first%0d: got %h want %h", i, obs, exp);
            end
        end
        fs = 1'b1; pv = 1'b0;
        step();
        fs = 1'b0;
        checks++;
        if ({valid_out, short_frame_out} !== 2'b01) begin
            errors++; $display("FAIL short_pulse: got %b want 01", {valid_out, short_frame_out});
        end
        for (int i = 1; i <= 8; i++) begin
            pv = 1'b1; pix = 12'(12'h310 + i);
            step();
            exp = {1'b1, i == 1, i == 8, 12'(12'h310 + i)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL short_second%0d: got %h want %h", i, obs, exp);
            end
            if (i == 1) begin
                checks++;
                if (short_frame_out !== 1'b0) begin
                    errors++; $display("FAIL short_once: got %b want 0", short_frame_out);
                end
            end
        end
        pv = 1'b0;
        step();
        checks++;
        if ({valid_out, frame_done_out} !== 2'b01) begin
            errors++; $display("FAIL short_done: got %b want 01", {valid_out, frame_done_out});
        end
    endtask

    task automatic test_stray();
        apply_reset();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pv = 1'b1; pix = 12'(12'h0a0 + i);
            step();
            checks++;
            if ({obs, flags} !== 18'h0) begin
                errors++; $display("FAIL stray%0d: got %h want 0", i, {obs, flags});
            end
        end
        pv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_overflow();
        test_short_frame();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
